pci_target: RTL and testbench

PCI_TARGET -- requirements
Module: pci_target

---
 rtl/pci_pkg.sv | 9 +
 rtl/pci_target_mem.sv | 20 ++
 rtl/pci_target.sv | 90 +++++++++
 tb/tb_pci_target.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/pci_pkg.sv
// pci_pkg: state encoding and memory command codes shared by the PCI target and initiator.
package pci_pkg;
  typedef enum logic [2:0] {IDLE, DECODE, TURNAROUND, DATA, BACKOFF} pci_state_t;
  localparam logic [3:0] CMD_MEM_READ  = 4'b0110;
  localparam logic [3:0] CMD_MEM_WRITE = 4'b0111;
  function automatic logic is_mem_cmd(input logic [3:0] cmd);
    return cmd == CMD_MEM_READ || cmd == CMD_MEM_WRITE;
  endfunction
endpackage

// File: rtl/pci_target_mem.sv
// pci_target_mem: 32-bit register file with active-low byte-enable write, async read and async clear.
module pci_target_mem #(
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       we,
  input  logic [$clog2(DEPTH)-1:0]   addr,
  input  logic [3:0]                 be_n,
  input  logic [31:0]                wdata,
  output logic [31:0]                rdata
);
  logic [31:0] mem [DEPTH];
  always_ff @(posedge clk or posedge rst)
    if (rst) mem <= '{default: '0};
    else if (we)
      for (int i = 0; i < 4; i++)
        if (!be_n[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
  assign rdata = mem[addr];
endmodule

// File: rtl/pci_target.sv
// pci_target: PCI memory-read/write target with burst transfers into a small word memory.
module pci_target
  import pci_pkg::*;
#(
  parameter logic [1:0] DEV_ADDR  = 2'd0,
  parameter int         MEM_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  inout  tri   [31:0] AD,
  input  logic [3:0]  C_BE,
  input  logic        frame,
  input  logic        irdy,
  output logic        trdy,
  output logic        devsel,
  output logic        busy
);
  localparam int PW = $clog2(MEM_DEPTH);
  pci_state_t    state;
  logic [PW-1:0] ptr;
  logic          cmd_wr, frame_q;
  logic          devsel_oe, devsel_v, trdy_oe, trdy_v, ad_oe;
  logic [31:0]   rdata;
  logic          claim;
  // A claim needs a fresh falling edge of frame so a long-held frame is not re-decoded.
  assign claim = !frame && frame_q && AD[1:0] == DEV_ADDR && is_mem_cmd(C_BE);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      cmd_wr    <= 1'b0;
      frame_q   <= 1'b1;
      devsel_oe <= 1'b0;
      devsel_v  <= 1'b1;
      trdy_oe   <= 1'b0;
      trdy_v    <= 1'b1;
      ad_oe     <= 1'b0;
    end else begin
      frame_q <= frame;
      case (state)
        IDLE: if (claim) begin
          state     <= DECODE;
          cmd_wr    <= C_BE == CMD_MEM_WRITE;
          ptr       <= AD[PW+1:2];
          devsel_oe <= 1'b1;
          devsel_v  <= 1'b0;
          trdy_oe   <= 1'b1;
          trdy_v    <= 1'b1;
        end
        DECODE: begin
          state  <= cmd_wr ? DATA : TURNAROUND;
          trdy_v <= !cmd_wr;
        end
        TURNAROUND: begin
          state  <= DATA;
          trdy_v <= 1'b0;
          ad_oe  <= 1'b1;
        end
        // frame high ends the burst: final transfer if irdy low, abandon otherwise.
        DATA: begin
          if (!irdy) ptr <= ptr + 1'b1;
          if (frame) begin
            state    <= BACKOFF;
            devsel_v <= 1'b1;
            trdy_v   <= 1'b1;
            ad_oe    <= 1'b0;
          end
        end
        BACKOFF: begin
          state     <= IDLE;
          devsel_oe <= 1'b0;
          trdy_oe   <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  pci_target_mem #(.DEPTH(MEM_DEPTH)) u_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (state == DATA && !irdy && cmd_wr),
    .addr  (ptr),
    .be_n  (C_BE),
    .wdata (AD),
    .rdata (rdata)
  );
  assign AD     = ad_oe ? rdata : 'z;
  assign devsel = devsel_oe ? devsel_v : 1'bz;
  assign trdy   = trdy_oe ? trdy_v : 1'bz;
  assign busy   = state != IDLE;
endmodule

// File: tb/tb_pci_target.sv
// tb_pci_target: directed PCI transactions against pci_target with hand-computed expectations.
module tb_pci_target;
  import pci_pkg::*;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  C_BE = 4'h0;
  logic        frame = 1'b1;
  logic        irdy = 1'b1;
  logic        drv = 1'b0;
  logic [31:0] ad_drv = '0;
  wire  [31:0] AD;
  wire         trdy, devsel;
  logic        busy;
  int          tests = 0;
  int          fails = 0;
  logic [31:0] model [8];
  logic [31:0] wd [4];
  // Released control lines read high through the pullups.
  assign AD = drv ? ad_drv : 'z;
  pullup (trdy);
  pullup (devsel);
  pci_target #(.DEV_ADDR(2'd1)) dut (
    .clk    (clk),
    .rst    (rst),
    .AD     (AD),
    .C_BE   (C_BE),
    .frame  (frame),
    .irdy   (irdy),
    .trdy   (trdy),
    .devsel (devsel),
    .busy   (busy)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic addr_phase(input logic [31:0] a, input logic [3:0] cmd);
    drv = 1'b1;
    ad_drv = a;
    C_BE = cmd;
    frame = 1'b0;
    irdy = 1'b1;
    cyc();
  endtask
  task automatic backoff();
    check("backoff_devsel", {31'b0, devsel}, 32'd1);
    check("backoff_trdy", {31'b0, trdy}, 32'd1);
    check("backoff_busy", {31'b0, busy}, 32'd1);
    frame = 1'b1;
    irdy = 1'b1;
    drv = 1'b0;
    C_BE = 4'h0;
    cyc();
    check("idle_busy", {31'b0, busy}, 32'd0);
    check("idle_devsel", {31'b0, devsel}, 32'd1);
  endtask
  task automatic wr(input logic [31:0] a, input int n, input logic [3:0] be);
    addr_phase(a, CMD_MEM_WRITE);
    check("wr_decode_devsel", {31'b0, devsel}, 32'd0);
    check("wr_decode_busy", {31'b0, busy}, 32'd1);
    ad_drv = wd[0];
    C_BE = be;
    irdy = 1'b0;
    frame = (n == 1);
    cyc();
    check("wr_data_trdy", {31'b0, trdy}, 32'd0);
    check("wr_data_devsel", {31'b0, devsel}, 32'd0);
    for (int i = 0; i < n; i++) begin
      cyc();
      if (i < n - 1) begin
        check("wr_burst_devsel", {31'b0, devsel}, 32'd0);
        ad_drv = wd[i+1];
        frame = (i + 1 == n - 1);
      end
    end
    backoff();
  endtask
  task automatic rd(input logic [31:0] a, input int n);
    logic [2:0] w;
    w = a[4:2];
    addr_phase(a, CMD_MEM_READ);
    check("rd_decode_devsel", {31'b0, devsel}, 32'd0);
    check("rd_decode_trdy", {31'b0, trdy}, 32'd1);
    drv = 1'b0;
    cyc();
    check("rd_turn_devsel", {31'b0, devsel}, 32'd0);
    check("rd_turn_trdy", {31'b0, trdy}, 32'd1);
    irdy = 1'b0;
    frame = (n == 1);
    cyc();
    check("rd_data_trdy", {31'b0, trdy}, 32'd0);
    check("rd_data0", AD, model[w]);
    for (int i = 0; i < n; i++) begin
      cyc();
      if (i < n - 1) begin
        check("rd_data", AD, model[3'(w + 3'(i + 1))]);
        frame = (i + 1 == n - 1);
      end
    end
    backoff();
  endtask
  task automatic abort_chk(input logic [31:0] a, input logic [3:0] cmd);
    addr_phase(a, cmd);
    check("abort_busy", {31'b0, busy}, 32'd0);
    check("abort_devsel", {31'b0, devsel}, 32'd1);
    ad_drv = 32'h0;
    C_BE = 4'h0;
    irdy = 1'b0;
    cyc();
    check("abort_trdy", {31'b0, trdy}, 32'd1);
    check("abort_busy2", {31'b0, busy}, 32'd0);
    frame = 1'b1;
    cyc();
    irdy = 1'b1;
    drv = 1'b0;
    cyc();
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    for (int i = 0; i < 8; i++) model[i] = 32'h0;
    #2 rst = 1'b1;
    repeat (2) cyc();
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_devsel", {31'b0, devsel}, 32'd1);
    check("rst_trdy", {31'b0, trdy}, 32'd1);
    rst = 1'b0;
    cyc();
    check("post_rst_busy", {31'b0, busy}, 32'd0);
    wd[0] = 32'hA5A5A5A5;
    wd[1] = 32'h12345678;
    wr(32'h1, 2, 4'h0);
    model[0] = 32'hA5A5A5A5;
    model[1] = 32'h12345678;
    wd[0] = 32'hDEADBEEF;
    wd[1] = 32'h0BADF00D;
    wr(32'h9, 2, 4'h0);
    model[2] = 32'hDEADBEEF;
    model[3] = 32'h0BADF00D;
    rd(32'h1, 4);
    wd[0] = 32'h11111111;
    wd[1] = 32'h22222222;
    wr(32'h1D, 2, 4'h0);
    model[7] = 32'h11111111;
    model[0] = 32'h22222222;
    rd(32'h1D, 2);
    wd[0] = 32'hFFFFFFFF;
    wr(32'h11, 1, 4'b1100);
    model[4] = 32'h0000FFFF;
    rd(32'h11, 1);
    abort_chk(32'h10, CMD_MEM_WRITE);
    abort_chk(32'h11, 4'b0010);
    rd(32'h11, 1);
    addr_phase(32'h5, CMD_MEM_WRITE);
    ad_drv = 32'hFFFFFFFF;
    C_BE = 4'h0;
    frame = 1'b1;
    cyc();
    check("abandon_trdy", {31'b0, trdy}, 32'd0);
    cyc();
    backoff();
    rd(32'h5, 1);
    addr_phase(32'h1, CMD_MEM_READ);
    drv = 1'b0;
    cyc();
    irdy = 1'b0;
    cyc();
    check("stall_data0", AD, 32'h22222222);
    cyc();
    check("stall_data1", AD, 32'h12345678);
    irdy = 1'b1;
    repeat (2) begin
      cyc();
      check("stall_hold", AD, 32'h12345678);
      check("stall_trdy", {31'b0, trdy}, 32'd0);
    end
    irdy = 1'b0;
    cyc();
    check("stall_data2", AD, 32'hDEADBEEF);
    #1 rst = 1'b1;
    #1;
    check("midrst_busy", {31'b0, busy}, 32'd0);
    check("midrst_devsel", {31'b0, devsel}, 32'd1);
    check("midrst_trdy", {31'b0, trdy}, 32'd1);
    irdy = 1'b1;
    frame = 1'b1;
    cyc();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) model[i] = 32'h0;
    cyc();
    rd(32'h1, 4);
    rd(32'h11, 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
